// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_unit_fifo.sv
// Fetch-entry FIFO: power-of-2 depth, flush, simultaneous push/pop even when full.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full,
  output logic [PW:0]  count
);
  typedef logic [PW:0]   cnt_t;
  typedef logic [PW-1:0] ptr_t;

  ptr_t         wr_q, wr_d, rd_q, rd_d;
  cnt_t         count_q, count_d;
  fetch_entry_t mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == cnt_t'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Head reads as zero while empty so stale entries never leak out.
  assign head    = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + ptr_t'(1);
      if (do_pop)  rd_d = rd_q + ptr_t'(1);
      count_d = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: PC generation, credit-based imem issue, redirect/discard tracking,
// and an instruction buffer feeding decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = 4,
  parameter int                MAX_OUT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst_data,
  input  logic              inst_ready
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(FIFO_DEPTH + MAX_OUT + 1) + 1;
  typedef logic [CW-1:0] ctr_t;
  typedef logic [SW-1:0] sum_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
  ctr_t              out_q, out_d, disc_q, disc_d, live;
  sum_t              occ;
  logic              gnt_fire, rsp, push, pop, fifo_empty, fifo_full;
  logic [FW:0]       fifo_count;
  fetch_entry_t      head;
  logic              unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign redir_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign live        = out_q - disc_q;
  assign occ         = sum_t'(fifo_count) + sum_t'(live);

  // Every live request holds a reserved FIFO slot, so a response can always be pushed.
  assign imem_req  = rst_n && (out_q < ctr_t'(MAX_OUT)) &&
                     (occ < sum_t'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;
  // Stray responses after reset release are ignored rather than underflowing the count.
  assign rsp       = imem_rvalid && (out_q != '0);
  assign push      = rsp && (disc_q == '0) && !redirect_valid;
  assign pop       = inst_valid && inst_ready;

  always_comb begin
    out_d      = out_q + ctr_t'(gnt_fire) - ctr_t'(rsp);
    disc_d     = disc_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      disc_d     = out_d;
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
    end else begin
      if (rsp && (disc_q != '0)) disc_d = disc_q - ctr_t'(1);
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     resp_pc_d  = resp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ('{pc: resp_pc_q, data: imem_rdata}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = head.pc;
  assign inst_data  = head.data;

`ifndef SYNTHESIS
  a_out_max:  assert property (@(posedge clk) disable iff (!rst_n) out_q <= ctr_t'(MAX_OUT));
  a_disc_out: assert property (@(posedge clk) disable iff (!rst_n) disc_q <= out_q);
  a_credit:   assert property (@(posedge clk) disable iff (!rst_n) occ <= sum_t'(FIFO_DEPTH));
  a_no_ovf:   assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: in-order latency memory plus an epoch-tagged
// request/expected-instruction model, checked every cycle, with directed literal checks.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
    .inst_ready(inst_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t       memq[$];
  ent_t        expq[$];
  logic [31:0] m_pc = 32'h3000;
  int          m_ep = 0;
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: granted requests carry the epoch they were issued in; only responses of
  // the current epoch (and not in a redirect cycle) become instructions for decode.
  always @(posedge clk or negedge rst_n) begin
    mreq_t r;
    if (!rst_n) begin
      memq.delete();
      expq.delete();
      m_pc = 32'h3000;
      m_ep++;
    end else begin
      if (inst_valid && inst_ready && expq.size() != 0) void'(expq.pop_front());
      if (imem_rvalid && memq.size() != 0) begin
        r = memq.pop_front();
        if (!redirect_valid && r.ep == m_ep) expq.push_back('{pc: r.addr, data: mem_word(r.addr)});
      end
      if (imem_req && imem_gnt) begin
        memq.push_back('{addr: m_pc, due: cyc + int'($urandom_range(lat_hi, lat_lo)), ep: m_ep});
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        expq.delete();
        m_ep++;
        m_pc = {redirect_pc[31:2], 2'b00};
      end
      cyc++;
    end
  end

  // In-order memory: head response is driven once its due cycle is reached.
  always @(negedge clk) begin
    if (rst_n && memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      int live;
      live = 0;
      foreach (memq[i]) if (memq[i].ep == m_ep) live++;
      chk("inst_valid", 32'(inst_valid), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
        chk("inst_pc", inst_pc, expq[0].pc);
        chk("inst_data", inst_data, expq[0].data);
      end
      chk("imem_req", 32'(imem_req),
          32'(memq.size() < 2 && expq.size() + live < 4 && !redirect_valid));
      chk("imem_addr", imem_addr, m_pc);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic        found;
    int          n;
    logic [31:0] got [3];

    // Streaming with latency 1
    do_reset();
    imem_gnt = 1; inst_ready = 1; lat_lo = 1; lat_hi = 1;
    #2 chk("t1_addr0", imem_addr, 32'h3000); chk("t1_v0", 32'(inst_valid), 0);
    @(negedge clk); #2 chk("t1_addr1", imem_addr, 32'h3004); chk("t1_v1", 32'(inst_valid), 0);
    @(negedge clk); #2 chk("t1_addr2", imem_addr, 32'h3008); chk("t1_v2", 32'(inst_valid), 1);
    chk("t1_pc", inst_pc, 32'h3000); chk("t1_data", inst_data, 32'hF0DE_1234);
    repeat (20) @(negedge clk);

    // Back-pressure fills the buffer, then drains
    do_reset();
    imem_gnt = 1; inst_ready = 0;
    repeat (12) @(negedge clk);
    #2 chk("t2_req_stall", 32'(imem_req), 0); chk("t2_addr", imem_addr, 32'h3010);
    chk("t2_head", inst_pc, 32'h3000);
    @(negedge clk); inst_ready = 1;
    @(negedge clk); #2 chk("t2_resume_req", 32'(imem_req), 1); chk("t2_resume_addr", imem_addr, 32'h3010);
    repeat (10) @(negedge clk);

    // Redirect with two slow requests in flight
    do_reset();
    imem_gnt = 1; inst_ready = 1; lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_addr == 32'h3010) found = 1;
    end
    chk("t3_wait_addr", 32'(found), 1);
    pulse_redirect(32'h3100);
    #2 chk("t3_addr", imem_addr, 32'h3100);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #2;
      if (inst_valid) found = 1;
    end
    chk("t3_wait_valid", 32'(found), 1);
    chk("t3_pc", inst_pc, 32'h3100);
    repeat (5) @(negedge clk);

    // Grant stall keeps request stable
    do_reset();
    imem_gnt = 0; inst_ready = 1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("t4_req", 32'(imem_req), 1); chk("t4_addr", imem_addr, 32'h3000);
      @(negedge clk);
    end
    imem_gnt = 1;
    @(negedge clk); imem_gnt = 0;
    #2 chk("t4_adv", imem_addr, 32'h3004);

    // Unaligned redirect and address wrap
    @(negedge clk); imem_gnt = 1;
    pulse_redirect(32'h3103);
    #2 chk("t5_align", imem_addr, 32'h3100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (inst_valid) found = 1;
    end
    chk("t5_pc", inst_pc, 32'h3100);
    @(negedge clk);
    pulse_redirect(32'hFFFF_FFF8);
    n = 0;
    for (int i = 0; i < 3; i++) got[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && n < 3; i++) begin
      #2;
      if (imem_req) begin got[n] = imem_addr; n++; end
      @(negedge clk);
    end
    chk("t5_wrap0", got[0], 32'hFFFF_FFF8);
    chk("t5_wrap1", got[1], 32'hFFFF_FFFC);
    chk("t5_wrap2", got[2], 32'h0000_0000);
    repeat (5) @(negedge clk);

    // Asynchronous reset with the buffer partly full
    do_reset();
    imem_gnt = 1; inst_ready = 1;
    repeat (6) @(negedge clk);
    inst_ready = 0;
    repeat (2) @(negedge clk);
    #2 chk("t6_pre_valid", 32'(inst_valid), 1);
    @(negedge clk);
    #3 rst_n = 0;
    #1 chk("t6_valid", 32'(inst_valid), 0); chk("t6_req", 32'(imem_req), 0);
    chk("t6_pc", inst_pc, 0); chk("t6_data", inst_data, 0); chk("t6_addr", imem_addr, 32'h3000);
    @(negedge clk); @(negedge clk);
    rst_n = 1; imem_gnt = 1; inst_ready = 1;
    #2 chk("t6_first_req", 32'(imem_req), 1); chk("t6_first_addr", imem_addr, 32'h3000);

    // Random traffic against the model
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 1000) begin
        do_reset();
      end
      imem_gnt   = ($urandom_range(0, 9) < 7);
      inst_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       redirect_pc = $urandom;
          1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          default: redirect_pc = 32'h3000 + 32'($urandom_range(0, 255));
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    redirect_valid = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
